// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit_if
// Description : Instruction-memory bus between the fetch stage and the
//               synchronous instruction BRAM.
//               imem_addr  - word address driven by the fetch stage
//               imem_rdata - BRAM read data, valid one cycle after imem_addr
//               master : fetch stage (drives the address)
//               slave  : instruction BRAM (returns the data)
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_unit_if #(
  parameter int IMEM_ADDR_W = 14
);
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );
endinterface : ifetch_unit_if
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage for the single-cycle RV32I core.
//               Owns the PC, drives the synchronous instruction BRAM and
//               selects the next PC from the decoded control and ALU result.
//               Misaligned taken control-flow targets freeze the stage in a
//               sticky trap until reset.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               branch/jal/jalr  - decoded control-flow class of inst
//               zero             - ALU branch condition (1 = taken)
//               imm32            - sign-extended immediate
//               alu_result       - ALU output (rs1+imm for JALR)
//               stall            - hold the current instruction
//               imem             - instruction BRAM bus (master side)
//               inst, pc         - current instruction and its address
//               pc_plus4         - link value for JAL/JALR
//               inst_valid       - inst/pc describe a real instruction
//               misalign         - sticky misaligned-target trap flag
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 branch,
  input  wire                 jal,
  input  wire                 jalr,
  input  wire                 zero,
  input  wire  [31:0]         imm32,
  input  wire  [31:0]         alu_result,
  input  wire                 stall,
  ifetch_unit_if.master       imem,
  output logic [31:0]         inst,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                inst_valid,
  output logic                misalign
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_misalign;
  logic        w_misalign_nxt;
  logic        w_inst_valid;
  logic [31:0] w_fetch_addr;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_rel;
  logic [31:0] w_jalr_target;
  logic        w_redirect;
  logic [31:0] w_next_pc;
  logic        w_target_bad;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_pc_rel      = r_pc + imm32;
  // JALR clears bit 0 of the computed target before use.
  assign w_jalr_target = alu_result & ~32'h0000_0001;
  assign w_redirect    = jalr | jal | (branch & zero);

  // Priority jalr > jal > taken branch > sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jalr) begin
      w_next_pc = w_jalr_target;
    end else if (jal || (branch && zero)) begin
      w_next_pc = w_pc_rel;
    end
  end

  // The sequential path is always aligned, so only a redirect can fault.
  assign w_target_bad = w_redirect && (w_next_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_PRIME;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = r_misalign;
    w_inst_valid   = 1'b0;
    w_fetch_addr   = r_pc;
    case (r_state)
      ST_PRIME: begin
        // Fetch of pc is in flight; the BRAM answers next cycle.
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_inst_valid = 1'b1;
        if (!stall) begin
          if (w_target_bad) begin
            w_state_nxt    = ST_TRAP;
            w_misalign_nxt = 1'b1;
          end else begin
            // Fetch next_pc now so its word lands together with the new pc.
            w_pc_nxt     = w_next_pc;
            w_fetch_addr = w_next_pc;
          end
        end
      end
      ST_TRAP: begin
        w_misalign_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_PRIME;
      end
    endcase
  end

  assign imem.imem_addr = w_fetch_addr[IMEM_ADDR_W+1:2];

  // Bits outside the BRAM word index are intentionally dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{w_fetch_addr[31:IMEM_ADDR_W+2], w_fetch_addr[1:0]};

  assign inst_valid = w_inst_valid;
  assign inst       = w_inst_valid ? imem.imem_rdata : C_NOP;
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misalign   = r_misalign;

endmodule : ifetch_unit
`default_nettype wire
